// File: rtl/vfr_multibank_controller.sv
// Multi-bank frame-reader sequencer.
// Picks a frame-buffer bank per frame, programs the packet reader through a
// simple write master (base, samples, words, type, go), triggers the
// control-packet encoder, then waits for the end-of-packet interrupt.
// A non-zero timeout aborts the frame and raises a sticky error.
module vfr_multibank_controller #(
    parameter int NUM_BANKS        = 4,
    parameter int BANK_SEL_WIDTH   = 2,
    parameter int RES_WIDTH        = 16,
    parameter int INTERLACED_WIDTH = 4,
    parameter int PACKET_WIDTH     = 32,
    parameter int TIMEOUT_WIDTH    = 24
) (
    input  logic                                  clock,
    input  logic                                  reset,
    output logic [31:0]                           master_address,
    output logic                                  master_write,
    output logic [31:0]                           master_writedata,
    input  logic                                  master_waitrequest,
    input  logic                                  master_interrupt_recieve,
    input  logic                                  go_bit,
    input  logic                                  continuous_mode,
    input  logic                                  auto_advance,
    input  logic [BANK_SEL_WIDTH-1:0]             next_bank,
    input  logic [TIMEOUT_WIDTH-1:0]              timeout_cycles,
    input  logic                                  timeout_clear,
    input  logic [NUM_BANKS*RES_WIDTH-1:0]        bank_width,
    input  logic [NUM_BANKS*RES_WIDTH-1:0]        bank_height,
    input  logic [NUM_BANKS*INTERLACED_WIDTH-1:0] bank_interlaced,
    input  logic [NUM_BANKS*PACKET_WIDTH-1:0]     bank_base_address,
    input  logic [NUM_BANKS*PACKET_WIDTH-1:0]     bank_samples,
    input  logic [NUM_BANKS*PACKET_WIDTH-1:0]     bank_words,
    output logic                                  running,
    output logic                                  frame_complete,
    output logic                                  timeout_error,
    output logic [BANK_SEL_WIDTH-1:0]             current_bank,
    output logic [15:0]                           frame_count,
    output logic [RES_WIDTH-1:0]                  width_of_next_vid_packet,
    output logic [RES_WIDTH-1:0]                  height_of_next_vid_packet,
    output logic [INTERLACED_WIDTH-1:0]           interlaced_of_next_vid_packet,
    output logic                                  do_control_packet
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_SEL      = 4'd1,
        S_ADDR     = 4'd2,
        S_SAMPLES  = 4'd3,
        S_WORDS    = 4'd4,
        S_TYPE     = 4'd5,
        S_GO       = 4'd6,
        S_WAIT_END = 4'd7,
        S_CLR_IRQ  = 4'd8,
        S_ABORT    = 4'd9
    } state_t;

    localparam logic [BANK_SEL_WIDTH:0]   LP_NB      = (BANK_SEL_WIDTH+1)'(NUM_BANKS);
    localparam logic [BANK_SEL_WIDTH-1:0] LP_LAST    = BANK_SEL_WIDTH'(NUM_BANKS - 1);
    localparam logic [BANK_SEL_WIDTH-1:0] LP_ONE     = BANK_SEL_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0]  LP_TMO_ONE = TIMEOUT_WIDTH'(1);

    state_t                      r_state;
    logic [BANK_SEL_WIDTH-1:0]   r_bank_ptr;   // bank of the previous frame; reset so auto-advance starts at 0
    logic [PACKET_WIDTH-1:0]     r_samples;
    logic [PACKET_WIDTH-1:0]     r_words;
    logic [TIMEOUT_WIDTH-1:0]    r_tmo_cnt;

    logic [BANK_SEL_WIDTH-1:0]   w_sel;
    int                          w_idx;
    logic [RES_WIDTH-1:0]        w_width;
    logic [RES_WIDTH-1:0]        w_height;
    logic [INTERLACED_WIDTH-1:0] w_il;
    logic [PACKET_WIDTH-1:0]     w_base;
    logic [PACKET_WIDTH-1:0]     w_samples;
    logic [PACKET_WIDTH-1:0]     w_words;
    logic                        w_tmo_hit;

    // Bank choice for the next frame and the fields of that bank
    always_comb begin
        if (auto_advance) begin
            if (r_bank_ptr == LP_LAST) begin
                w_sel = {BANK_SEL_WIDTH{1'b0}};
            end else begin
                w_sel = r_bank_ptr + LP_ONE;
            end
        end else begin
            if ({1'b0, next_bank} >= LP_NB) begin
                w_sel = {BANK_SEL_WIDTH{1'b0}};
            end else begin
                w_sel = next_bank;
            end
        end
        w_idx     = int'(w_sel);
        w_width   = bank_width[w_idx*RES_WIDTH +: RES_WIDTH];
        w_height  = bank_height[w_idx*RES_WIDTH +: RES_WIDTH];
        w_il      = bank_interlaced[w_idx*INTERLACED_WIDTH +: INTERLACED_WIDTH];
        w_base    = bank_base_address[w_idx*PACKET_WIDTH +: PACKET_WIDTH];
        w_samples = bank_samples[w_idx*PACKET_WIDTH +: PACKET_WIDTH];
        w_words   = bank_words[w_idx*PACKET_WIDTH +: PACKET_WIDTH];
    end

    // Timeout fires on the last permitted WAIT_END cycle; zero disables it
    always_comb begin
        w_tmo_hit = (timeout_cycles != {TIMEOUT_WIDTH{1'b0}}) &&
                    (r_tmo_cnt == (timeout_cycles - LP_TMO_ONE));
    end

    // Frame sequencer: each write state holds its bus outputs until accepted,
    // then loads the next write so the master is never idle between writes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state                       <= S_IDLE;
            r_bank_ptr                    <= LP_LAST;
            r_samples                     <= {PACKET_WIDTH{1'b0}};
            r_words                       <= {PACKET_WIDTH{1'b0}};
            r_tmo_cnt                     <= {TIMEOUT_WIDTH{1'b0}};
            master_address                <= 32'd0;
            master_write                  <= 1'b0;
            master_writedata              <= 32'd0;
            running                       <= 1'b0;
            frame_complete                <= 1'b0;
            timeout_error                 <= 1'b0;
            current_bank                  <= {BANK_SEL_WIDTH{1'b0}};
            frame_count                   <= 16'd0;
            width_of_next_vid_packet      <= {RES_WIDTH{1'b0}};
            height_of_next_vid_packet     <= {RES_WIDTH{1'b0}};
            interlaced_of_next_vid_packet <= {INTERLACED_WIDTH{1'b0}};
            do_control_packet             <= 1'b0;
        end else begin
            frame_complete    <= 1'b0;
            do_control_packet <= 1'b0;
            // a clear is overridden below when ABORT sets the flag this cycle
            if (timeout_clear) begin
                timeout_error <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    master_write <= 1'b0;
                    if (go_bit) begin
                        r_state <= S_SEL;
                        running <= 1'b1;
                    end
                end
                S_SEL: begin
                    r_bank_ptr                    <= w_sel;
                    current_bank                  <= w_sel;
                    r_samples                     <= w_samples;
                    r_words                       <= w_words;
                    width_of_next_vid_packet      <= w_width;
                    height_of_next_vid_packet     <= w_height;
                    interlaced_of_next_vid_packet <= w_il;
                    do_control_packet             <= 1'b1;
                    master_address                <= 32'd3;
                    master_writedata              <= 32'(w_base);
                    master_write                  <= 1'b1;
                    r_state                       <= S_ADDR;
                end
                S_ADDR: begin
                    if (!master_waitrequest) begin
                        master_address   <= 32'd5;
                        master_writedata <= 32'(r_samples);
                        r_state          <= S_SAMPLES;
                    end
                end
                S_SAMPLES: begin
                    if (!master_waitrequest) begin
                        master_address   <= 32'd6;
                        master_writedata <= 32'(r_words);
                        r_state          <= S_WORDS;
                    end
                end
                S_WORDS: begin
                    if (!master_waitrequest) begin
                        master_address   <= 32'd4;
                        master_writedata <= 32'd0;
                        r_state          <= S_TYPE;
                    end
                end
                S_TYPE: begin
                    if (!master_waitrequest) begin
                        master_address   <= 32'd0;
                        master_writedata <= 32'd3;
                        r_state          <= S_GO;
                    end
                end
                S_GO: begin
                    if (!master_waitrequest) begin
                        master_write <= 1'b0;
                        r_tmo_cnt    <= {TIMEOUT_WIDTH{1'b0}};
                        r_state      <= S_WAIT_END;
                    end
                end
                S_WAIT_END: begin
                    r_tmo_cnt <= r_tmo_cnt + LP_TMO_ONE;
                    if (master_interrupt_recieve) begin
                        master_address   <= 32'd2;
                        master_writedata <= 32'd2;
                        master_write     <= 1'b1;
                        r_state          <= S_CLR_IRQ;
                    end else if (w_tmo_hit) begin
                        master_address   <= 32'd0;
                        master_writedata <= 32'd0;
                        master_write     <= 1'b1;
                        r_state          <= S_ABORT;
                    end
                end
                S_CLR_IRQ: begin
                    if (!master_waitrequest) begin
                        master_write   <= 1'b0;
                        frame_complete <= 1'b1;
                        frame_count    <= frame_count + 16'd1;
                        if (continuous_mode && go_bit) begin
                            r_state <= S_SEL;
                        end else begin
                            running <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ABORT: begin
                    if (!master_waitrequest) begin
                        master_write  <= 1'b0;
                        timeout_error <= 1'b1;
                        running       <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    master_write <= 1'b0;
                    running      <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vfr_multibank_controller.sv
// Self-checking bench for vfr_multibank_controller: a transaction-level model
// (expected write list, expected frame banks, expected encoder values) is
// checked every cycle, plus directed literal checks on key scenarios.
module tb_vfr_multibank_controller;
    localparam int NB = 4, BSW = 3, RW = 16, IW = 4, PW = 32, TW = 24;

    logic               clock;
    logic               reset;
    logic [31:0]        master_address;
    logic               master_write;
    logic [31:0]        master_writedata;
    logic               master_waitrequest;
    logic               master_interrupt_recieve;
    logic               go_bit;
    logic               continuous_mode;
    logic               auto_advance;
    logic [BSW-1:0]     next_bank;
    logic [TW-1:0]      timeout_cycles;
    logic               timeout_clear;
    logic [NB*RW-1:0]   bank_width;
    logic [NB*RW-1:0]   bank_height;
    logic [NB*IW-1:0]   bank_interlaced;
    logic [NB*PW-1:0]   bank_base_address;
    logic [NB*PW-1:0]   bank_samples;
    logic [NB*PW-1:0]   bank_words;
    logic               running;
    logic               frame_complete;
    logic               timeout_error;
    logic [BSW-1:0]     current_bank;
    logic [15:0]        frame_count;
    logic [RW-1:0]      width_of_next_vid_packet;
    logic [RW-1:0]      height_of_next_vid_packet;
    logic [IW-1:0]      interlaced_of_next_vid_packet;
    logic               do_control_packet;

    vfr_multibank_controller #(
        .NUM_BANKS(NB), .BANK_SEL_WIDTH(BSW), .RES_WIDTH(RW),
        .INTERLACED_WIDTH(IW), .PACKET_WIDTH(PW), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clock(clock), .reset(reset),
        .master_address(master_address), .master_write(master_write),
        .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
        .master_interrupt_recieve(master_interrupt_recieve),
        .go_bit(go_bit), .continuous_mode(continuous_mode), .auto_advance(auto_advance),
        .next_bank(next_bank), .timeout_cycles(timeout_cycles), .timeout_clear(timeout_clear),
        .bank_width(bank_width), .bank_height(bank_height), .bank_interlaced(bank_interlaced),
        .bank_base_address(bank_base_address), .bank_samples(bank_samples), .bank_words(bank_words),
        .running(running), .frame_complete(frame_complete), .timeout_error(timeout_error),
        .current_bank(current_bank), .frame_count(frame_count),
        .width_of_next_vid_packet(width_of_next_vid_packet),
        .height_of_next_vid_packet(height_of_next_vid_packet),
        .interlaced_of_next_vid_packet(interlaced_of_next_vid_packet),
        .do_control_packet(do_control_packet)
    );

    int total = 0;
    int bad   = 0;

    // model state
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_bank[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_h[$];
    logic [31:0] exp_i[$];
    int          mdl_prev   = -1;
    int          mdl_frames = 0;
    int          frames_seen = 0;
    int          ctl_seen   = 0;
    int          cnt5       = 0;

    // stimulus knobs
    int          irq_delay  = 0;
    int          stall_left = 0;
    logic [31:0] stall_addr = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // model: decide the bank and queue every expected transaction of one frame
    // end_kind: 0 = no end, 1 = interrupt end, 2 = timeout abort
    task automatic plan_frame(input int end_kind);
        int b;
        if (auto_advance) b = (mdl_prev + 1) % NB;
        else if (int'(next_bank) < NB) b = int'(next_bank);
        else b = 0;
        mdl_prev = b;
        exp_addr.push_back(32'd3); exp_data.push_back(bank_base_address[b*PW +: PW]);
        exp_addr.push_back(32'd5); exp_data.push_back(bank_samples[b*PW +: PW]);
        exp_addr.push_back(32'd6); exp_data.push_back(bank_words[b*PW +: PW]);
        exp_addr.push_back(32'd4); exp_data.push_back(32'd0);
        exp_addr.push_back(32'd0); exp_data.push_back(32'd3);
        if (end_kind == 1) begin
            exp_addr.push_back(32'd2); exp_data.push_back(32'd2);
            exp_bank.push_back(b);
        end else if (end_kind == 2) begin
            exp_addr.push_back(32'd0); exp_data.push_back(32'd0);
        end
        exp_w.push_back(32'(bank_width[b*RW +: RW]));
        exp_h.push_back(32'(bank_height[b*RW +: RW]));
        exp_i.push_back(32'(bank_interlaced[b*IW +: IW]));
    endtask

    task automatic clear_model();
        exp_addr.delete(); exp_data.delete(); exp_bank.delete();
        exp_w.delete(); exp_h.delete(); exp_i.delete();
        mdl_prev = -1; mdl_frames = 0; frames_seen = 0; ctl_seen = 0; cnt5 = 0;
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_addr"},  master_address, 32'd0);
        chk({nm, "_write"}, 32'(master_write), 32'd0);
        chk({nm, "_data"},  master_writedata, 32'd0);
        chk({nm, "_run"},   32'(running), 32'd0);
        chk({nm, "_fc"},    32'(frame_complete), 32'd0);
        chk({nm, "_terr"},  32'(timeout_error), 32'd0);
        chk({nm, "_bank"},  32'(current_bank), 32'd0);
        chk({nm, "_cnt"},   32'(frame_count), 32'd0);
        chk({nm, "_w"},     32'(width_of_next_vid_packet), 32'd0);
        chk({nm, "_h"},     32'(height_of_next_vid_packet), 32'd0);
        chk({nm, "_il"},    32'(interlaced_of_next_vid_packet), 32'd0);
        chk({nm, "_ctl"},   32'(do_control_packet), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        clear_model();
        check_zero("rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_go();
        go_bit = 1'b1;
        @(negedge clock);
        go_bit = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, input string nm);
        int n = 0;
        while (frames_seen < target && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 32'(frames_seen), 32'(target));
    endtask

    task automatic wait_accept(input logic [31:0] a, input logic [31:0] d, input int budget, input string nm);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clock);
            n++;
            seen = master_write && master_address == a && master_writedata == d && !master_waitrequest;
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // slave stall driver: holds waitrequest for stall_left cycles on the chosen register
    initial forever begin
        @(posedge clock);
        #1;
        if (stall_left > 0 && master_write && master_address == stall_addr) begin
            master_waitrequest = 1'b1;
            stall_left--;
        end else begin
            master_waitrequest = 1'b0;
        end
    end

    // packet reader stand-in: interrupt irq_delay cycles after the GO write is accepted
    initial forever begin
        @(negedge clock);
        if (!reset && irq_delay != 0 && master_write && master_address == 32'd0 &&
            master_writedata == 32'd3 && !master_waitrequest) begin
            repeat (irq_delay) @(posedge clock);
            #1 master_interrupt_recieve = 1'b1;
            @(posedge clock);
            #1 master_interrupt_recieve = 1'b0;
        end
    end

    // compare process: every bus write, frame pulse and encoder trigger against the model
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (master_write) begin
                if (master_address == 32'd5) cnt5++;
                if (exp_addr.size() == 0) begin
                    chk("unexpected_write", master_address, 32'hFFFF_FFFF);
                end else begin
                    chk("wr_addr", master_address, exp_addr[0]);
                    chk("wr_data", master_writedata, exp_data[0]);
                    if (!master_waitrequest) begin
                        exp_addr.delete(0);
                        exp_data.delete(0);
                    end
                end
            end
            if (frame_complete) begin
                frames_seen++;
                mdl_frames++;
                chk("frame_count", 32'(frame_count), 32'(mdl_frames % 65536));
                if (exp_bank.size() == 0) begin
                    chk("unexpected_frame", 32'(current_bank), 32'hFFFF_FFFF);
                end else begin
                    chk("frame_bank", 32'(current_bank), 32'(exp_bank[0]));
                    exp_bank.delete(0);
                end
            end
            if (do_control_packet) begin
                ctl_seen++;
                if (exp_w.size() == 0) begin
                    chk("unexpected_ctl", 32'(width_of_next_vid_packet), 32'hFFFF_FFFF);
                end else begin
                    chk("enc_width", 32'(width_of_next_vid_packet), exp_w[0]);
                    chk("enc_height", 32'(height_of_next_vid_packet), exp_h[0]);
                    chk("enc_il", 32'(interlaced_of_next_vid_packet), exp_i[0]);
                    exp_w.delete(0); exp_h.delete(0); exp_i.delete(0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        master_waitrequest = 1'b0;
        master_interrupt_recieve = 1'b0;
        go_bit = 1'b0;
        continuous_mode = 1'b0;
        auto_advance = 1'b0;
        next_bank = 3'd0;
        timeout_cycles = 24'd0;
        timeout_clear = 1'b0;
        for (int k = 0; k < NB; k++) begin
            bank_base_address[k*PW +: PW] = 32'(k) * 32'h0008_0000;
            bank_samples[k*PW +: PW]      = 32'd1000 + 32'(k);
            bank_words[k*PW +: PW]        = 32'd2000 + 32'(k);
            bank_width[k*RW +: RW]        = 16'd640 + 16'(k);
            bank_height[k*RW +: RW]       = 16'd480 + 16'(k);
            bank_interlaced[k*IW +: IW]   = 4'(k + 1);
        end
        bank_width[2*RW +: RW]  = 16'd1920;
        bank_height[2*RW +: RW] = 16'd1080;

        // power-on reset state
        repeat (2) @(negedge clock);
        check_zero("por");
        reset = 1'b0;
        @(negedge clock);

        // explicit bank 2, stalled SAMPLES write, inputs changed mid-frame
        auto_advance = 1'b0; next_bank = 3'd2; irq_delay = 20;
        plan_frame(1);
        stall_addr = 32'd5; stall_left = 3;
        pulse_go();
        wait_accept(32'd3, 32'h0010_0000, 20, "a_base_write");
        chk("a_running", 32'(running), 32'd1);
        bank_samples[2*PW +: PW] = 32'hDEAD_BEEF;
        bank_width[2*RW +: RW]   = 16'd1;
        wait_frames(1, 200, "a_frame_done");
        @(negedge clock);
        chk("a_running_end", 32'(running), 32'd0);
        chk("a_count", 32'(frame_count), 32'd1);
        chk("a_bank", 32'(current_bank), 32'd2);
        chk("a_width", 32'(width_of_next_vid_packet), 32'd1920);
        chk("a_height", 32'(height_of_next_vid_packet), 32'd1080);
        chk("a_ctl_pulses", 32'(ctl_seen), 32'd1);
        chk("a_stall_cycles", 32'(cnt5), 32'd4);
        chk("a_writes_left", 32'(exp_addr.size()), 32'd0);
        bank_samples[2*PW +: PW] = 32'd1002;
        bank_width[2*RW +: RW]   = 16'd1920;

        // continuous round-robin: banks 0,1,2,3,0
        do_reset();
        auto_advance = 1'b1; continuous_mode = 1'b1; irq_delay = 20;
        for (int f = 0; f < 5; f++) plan_frame(1);
        go_bit = 1'b1;
        wait_frames(4, 600, "b_four_frames");
        go_bit = 1'b0;
        wait_frames(5, 200, "b_five_frames");
        repeat (3) @(negedge clock);
        chk("b_count", 32'(frame_count), 32'd5);
        chk("b_last_bank", 32'(current_bank), 32'd0);
        chk("b_running", 32'(running), 32'd0);
        chk("b_ctl_pulses", 32'(ctl_seen), 32'd5);
        chk("b_writes_left", 32'(exp_addr.size()), 32'd0);

        // timeout abort after 100 WAIT_END cycles
        continuous_mode = 1'b0; irq_delay = 0; timeout_cycles = 24'd100;
        plan_frame(2);
        pulse_go();
        wait_accept(32'd0, 32'd3, 20, "c_go_write");
        n = 0;
        do begin
            @(negedge clock);
            if (!master_write) n++;
        end while (!master_write && n < 300);
        chk("c_wait_cycles", 32'(n), 32'd100);
        chk("c_abort_addr", master_address, 32'd0);
        chk("c_abort_data", master_writedata, 32'd0);
        timeout_clear = 1'b1;
        @(negedge clock);
        timeout_clear = 1'b0;
        chk("c_terr_set_wins", 32'(timeout_error), 32'd1);
        chk("c_running", 32'(running), 32'd0);
        chk("c_count", 32'(frame_count), 32'd5);
        chk("c_bank", 32'(current_bank), 32'd1);
        repeat (3) @(negedge clock);
        chk("c_terr_sticky", 32'(timeout_error), 32'd1);
        timeout_clear = 1'b1;
        @(negedge clock);
        timeout_clear = 1'b0;
        chk("c_terr_cleared", 32'(timeout_error), 32'd0);

        // out-of-range next_bank, then reset during WAIT_END
        timeout_cycles = 24'd0; auto_advance = 1'b0; next_bank = 3'd5;
        plan_frame(0);
        pulse_go();
        wait_accept(32'd0, 32'd3, 20, "d_go_write");
        repeat (5) @(negedge clock);
        chk("d_bank", 32'(current_bank), 32'd0);
        chk("d_running", 32'(running), 32'd1);
        #2 reset = 1'b1;
        #1;
        clear_model();
        check_zero("midrst");
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        // first frame after reset behaves normally and starts at bank 0
        auto_advance = 1'b1; irq_delay = 10;
        plan_frame(1);
        pulse_go();
        wait_frames(1, 200, "e_frame_done");
        @(negedge clock);
        chk("e_count", 32'(frame_count), 32'd1);
        chk("e_bank", 32'(current_bank), 32'd0);
        chk("e_writes_left", 32'(exp_addr.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
